// File: rtl/mt_regfile_if.sv
// mt_regfile_if: register-file access bundle shared by decode (reads) and
// write-back (writes).
//   rd_tid, rd_addr0, rd_addr1 : read thread and register indices (decode)
//   rd_data0, rd_data1         : combinational read data
//   wr_en, wr_tid, wr_addr,
//   wr_data                    : write-back port
//   busy                       : clear sweep in progress
// Modports: master drives reads/writes, slave is the register file.
interface mt_regfile_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int TID_W  = 2
);
    logic [TID_W-1:0]  rd_tid;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic              wr_en;
    logic [TID_W-1:0]  wr_tid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output rd_tid, rd_addr0, rd_addr1,
        output wr_en, wr_tid, wr_addr, wr_data,
        input  rd_data0, rd_data1, busy
    );

    modport slave (
        input  rd_tid, rd_addr0, rd_addr1,
        input  wr_en, wr_tid, wr_addr, wr_data,
        output rd_data0, rd_data1, busy
    );
endinterface

// File: rtl/mt_regfile.sv
// mt_regfile: 4-thread x 32 x 64-bit general-purpose register file with two
// combinational read ports, one write port with write-through bypass, and a
// post-reset sequencer that zeroes every entry before writes are accepted.
//   clk   : clock
//   reset : synchronous, active-high reset (restarts the clear sweep)
//   bus   : mt_regfile_if slave modport (read ports, write port, busy)
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | sweeping clr_idx 0..127 writing zero; writes dropped, reads 0
// READY | normal operation until the next reset
module mt_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int TID_W  = 2
) (
    input logic        clk,
    input logic        reset,
    mt_regfile_if.slave bus
);
    localparam int IDX_W   = TID_W + ADDR_W;
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  clr_idx_q;
    logic              busy_q;

    // Asynchronous read rules out block RAM; this maps to registers/LUTRAM.
    logic [DATA_W-1:0] mem_q [ENTRIES];

    logic [IDX_W-1:0]  wr_idx;
    logic              wr_ok;

    assign wr_idx = {bus.wr_tid, bus.wr_addr};
    assign wr_ok  = bus.wr_en && (bus.wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_idx_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Storage is left alone on the reset edge itself; the sweep does the clearing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_ok) begin
                mem_q[wr_idx] <= bus.wr_data;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = '0;
        if (busy_q || addr == '0) begin
            data = '0;
        end else if (bus.wr_en && bus.wr_tid == bus.rd_tid && bus.wr_addr == addr) begin
            data = bus.wr_data;
        end else begin
            data = mem_q[{bus.rd_tid, addr}];
        end
        return data;
    endfunction

    always_comb begin
        bus.rd_data0 = read_port(bus.rd_addr0);
        bus.rd_data1 = read_port(bus.rd_addr1);
    end

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mt_regfile.sv
module tb_mt_regfile;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mt_regfile_if #(.DATA_W(64), .ADDR_W(5), .TID_W(2)) bus_if ();

    mt_regfile #(.DATA_W(64), .ADDR_W(5), .TID_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Counts edges until busy drops; expected sweep length is 128.
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (bus_if.busy && cnt < 400) begin
            tick();
            cnt++;
        end
        check64(tag, 64'(cnt), 64'd128);
    endtask

    task automatic do_write(input logic [1:0] tid, input logic [4:0] addr, input logic [63:0] data);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_tid  = tid;
        bus_if.wr_addr = addr;
        bus_if.wr_data = data;
        tick();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] tid, input logic [4:0] a0, input logic [4:0] a1);
        bus_if.rd_tid   = tid;
        bus_if.rd_addr0 = a0;
        bus_if.rd_addr1 = a1;
        #1;
    endtask

    task automatic sweep_zero(input string tag);
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 32; a++) begin
                rd(2'(t), 5'(a), 5'(31 - a));
                check64({tag, "_p0"}, bus_if.rd_data0, 64'd0);
                if (a[2:0] == 3'd3) check64({tag, "_p1"}, bus_if.rd_data1, 64'd0);
            end
        end
    endtask

    localparam logic [63:0] DEAD = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] V1   = 64'h01234567_89ABCDEF;
    localparam logic [63:0] ONES = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] A5   = 64'hA5A5A5A5_A5A5A5A5;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus_if.wr_en    = 1'b0;
        bus_if.wr_tid   = '0;
        bus_if.wr_addr  = '0;
        bus_if.wr_data  = '0;
        bus_if.rd_tid   = '0;
        bus_if.rd_addr0 = '0;
        bus_if.rd_addr1 = '0;

        // Initial reset, then busy and reads during the sweep.
        tick();
        tick();
        reset = 1'b0;
        check64("busy_after_reset", 64'(bus_if.busy), 64'd1);
        wait_clear("clear_len_first");
        check64("busy_ready", 64'(bus_if.busy), 64'd0);

        // Preload nonzero data, confirm it is visible, then reset and clear.
        do_write(2'd0, 5'd1,  DEAD);
        do_write(2'd1, 5'd17, DEAD);
        do_write(2'd2, 5'd30, DEAD);
        do_write(2'd3, 5'd31, DEAD);
        rd(2'd1, 5'd17, 5'd1);
        check64("preload_visible", bus_if.rd_data0, DEAD);
        rd(2'd1, 5'd17, 5'd17);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_tid  = 2'd1;
        bus_if.wr_addr = 5'd17;
        bus_if.wr_data = V1;
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.wr_en = 1'b0;
        check64("busy_read_zero", bus_if.rd_data0, 64'd0);
        wait_clear("clear_len_second");
        sweep_zero("clear_all");

        // Bypass, storage read and thread isolation.
        bus_if.wr_en   = 1'b1;
        bus_if.wr_tid  = 2'd2;
        bus_if.wr_addr = 5'd7;
        bus_if.wr_data = V1;
        rd(2'd2, 5'd7, 5'd7);
        check64("bypass_p0", bus_if.rd_data0, V1);
        check64("bypass_p1", bus_if.rd_data1, V1);
        rd(2'd1, 5'd7, 5'd7);
        check64("bypass_other_tid", bus_if.rd_data0, 64'd0);
        tick();
        bus_if.wr_en = 1'b0;
        rd(2'd2, 5'd7, 5'd0);
        check64("stored_p0", bus_if.rd_data0, V1);
        rd(2'd1, 5'd7, 5'd7);
        check64("isolated_tid1", bus_if.rd_data0, 64'd0);
        rd(2'd3, 5'd7, 5'd7);
        check64("isolated_tid3", bus_if.rd_data1, 64'd0);

        // Register 0 stays zero during and after a write.
        bus_if.wr_en   = 1'b1;
        bus_if.wr_tid  = 2'd0;
        bus_if.wr_addr = 5'd0;
        bus_if.wr_data = ONES;
        rd(2'd0, 5'd0, 5'd0);
        check64("r0_during_p0", bus_if.rd_data0, 64'd0);
        check64("r0_during_p1", bus_if.rd_data1, 64'd0);
        tick();
        bus_if.wr_en = 1'b0;
        rd(2'd0, 5'd0, 5'd0);
        check64("r0_after_p0", bus_if.rd_data0, 64'd0);
        check64("r0_after_p1", bus_if.rd_data1, 64'd0);

        // Writes while busy are dropped; reset at clear cycle 60 restarts the sweep.
        pulse_reset();
        for (int i = 0; i < 50; i++) tick();
        check64("busy_cycle50", 64'(bus_if.busy), 64'd1);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_tid  = 2'd3;
        bus_if.wr_addr = 5'd31;
        bus_if.wr_data = A5;
        rd(2'd3, 5'd31, 5'd31);
        check64("busy_no_bypass", bus_if.rd_data0, 64'd0);
        tick();
        do_write(2'd0, 5'd10, A5);
        for (int i = 52; i < 60; i++) tick();
        check64("busy_cycle60", 64'(bus_if.busy), 64'd1);
        pulse_reset();
        wait_clear("clear_len_restart");
        rd(2'd3, 5'd31, 5'd31);
        check64("dropped_t3_r31", bus_if.rd_data0, 64'd0);
        rd(2'd0, 5'd10, 5'd10);
        check64("dropped_t0_r10", bus_if.rd_data1, 64'd0);
        sweep_zero("restart_all");

        // Consecutive writes and dual-port reads.
        do_write(2'd1, 5'd5, 64'h11);
        do_write(2'd1, 5'd6, 64'h22);
        rd(2'd1, 5'd5, 5'd6);
        check64("pair_p0", bus_if.rd_data0, 64'h11);
        check64("pair_p1", bus_if.rd_data1, 64'h22);
        rd(2'd1, 5'd6, 5'd6);
        check64("same_p0", bus_if.rd_data0, 64'h22);
        check64("same_p1", bus_if.rd_data1, 64'h22);
        rd(2'd2, 5'd5, 5'd6);
        check64("pair_other_tid", bus_if.rd_data0 | bus_if.rd_data1, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
